// File: rtl/imm_packer_pkg.sv
// Shared types and constants for the LEGv8 immediate packer.
package imm_packer_pkg;

    typedef enum logic [1:0] {
        KIND_STUR = 2'b00,
        KIND_LDUR = 2'b01,
        KIND_CBZ  = 2'b10,
        KIND_RSVD = 2'b11
    } kind_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_RANGE  = 2'b01,
        ERR_KIND   = 2'b10,
        ERR_UNUSED = 2'b11
    } err_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EMIT,
        S_DONE,
        S_FULL
    } state_t;

    localparam int unsigned D_IMM_W  = 9;
    localparam int unsigned CB_IMM_W = 19;

    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

endpackage

// File: rtl/imm_fit.sv
// Signed range check of a 64-bit immediate against a W-bit field, plus truncation.
module imm_fit #(
    parameter int unsigned W = 9
) (
    input  logic [63:0]  i_value,
    output logic         o_fits,
    output logic [W-1:0] o_field
);

    // Bits from the field sign bit upward must all agree.
    logic [64-W:0] w_upper;

    assign w_upper = i_value[63:W-1];
    assign o_fits  = (&w_upper) | ~(|w_upper);
    assign o_field = i_value[W-1:0];

endmodule

// File: rtl/imm_packer.sv
// Encodes STUR/LDUR/CBZ requests into LEGv8 words and writes them to imem sequentially.
module imm_packer
    import imm_packer_pkg::*;
#(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_kind,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rn,
    input  logic [63:0]   in_imm,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW:0]   count,
    output logic          full
);

    localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

    state_t    r_state;
    kind_t     r_kind;
    logic [4:0]  r_rt;
    logic [4:0]  r_rn;
    logic [63:0] r_imm;
    logic        r_ok;
    err_code_t   r_code;
    logic [31:0] r_word;

    logic                w_d_fits;
    logic [D_IMM_W-1:0]  w_d_field;
    logic                w_cb_fits;
    logic [CB_IMM_W-1:0] w_cb_field;
    logic [31:0]         w_word;
    logic                w_ok;
    err_code_t           w_code;
    logic                w_last;

    imm_fit #(.W(D_IMM_W)) u_fit_d (
        .i_value (r_imm),
        .o_fits  (w_d_fits),
        .o_field (w_d_field)
    );

    imm_fit #(.W(CB_IMM_W)) u_fit_cb (
        .i_value (r_imm),
        .o_fits  (w_cb_fits),
        .o_field (w_cb_field)
    );

    assign w_last = ((count + 1'b1) == CAP);

    // Assemble the candidate word and classify the latched request.
    always_comb begin
        w_word = '0;
        w_ok   = 1'b0;
        w_code = ERR_NONE;
        case (r_kind)
            KIND_STUR: begin
                w_word = {OP_STUR, w_d_field, 2'b00, r_rn, r_rt};
                w_ok   = w_d_fits;
            end
            KIND_LDUR: begin
                w_word = {OP_LDUR, w_d_field, 2'b00, r_rn, r_rt};
                w_ok   = w_d_fits;
            end
            KIND_CBZ: begin
                w_word = {OP_CBZ, w_cb_field, r_rt};
                w_ok   = w_cb_fits;
            end
            default: begin
                w_ok = 1'b0;
            end
        endcase
        if (r_kind == KIND_RSVD) begin
            w_code = ERR_KIND;
        end else if (!w_ok) begin
            w_code = ERR_RANGE;
        end
    end

    // Request FSM with registered handshake, write strobe, error pulse and address counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_kind   <= KIND_STUR;
            r_rt     <= '0;
            r_rn     <= '0;
            r_imm    <= '0;
            r_ok     <= 1'b0;
            r_code   <= ERR_NONE;
            r_word   <= '0;
            in_ready <= 1'b1;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            count    <= '0;
            full     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    in_ready <= ~full;
                    if (in_valid && in_ready) begin
                        r_kind   <= kind_t'(in_kind);
                        r_rt     <= in_rt;
                        r_rn     <= in_rn;
                        r_imm    <= in_imm;
                        in_ready <= 1'b0;
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_ok    <= w_ok;
                    r_code  <= w_code;
                    r_word  <= w_word;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (r_ok) begin
                        wr_en   <= 1'b1;
                        wr_data <= r_word;
                    end else begin
                        err      <= 1'b1;
                        err_code <= r_code;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    wr_en    <= 1'b0;
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                    if (r_ok) begin
                        count <= count + 1'b1;
                        // Address holds at the top slot instead of wrapping to zero.
                        if (!w_last) begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                    if (r_ok && w_last) begin
                        full     <= 1'b1;
                        in_ready <= 1'b0;
                        r_state  <= S_FULL;
                    end else begin
                        in_ready <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_FULL: begin
                    in_ready <= 1'b0;
                    wr_en    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
